sha2_w_sched_iter: RTL and testbench
====================================

# sha2_w_sched_iter

Parametrised, iterative SHA-2 message-schedule generator for the double-SHA pipeline. It loads one 16-word message block and streams the full schedule W_0..W_{ROUNDS-1}, STEPS words per handshake, to a downstream compression core. SHA-256 and SHA-512 are both supported through parameters. It replaces per-round fixed expansion stages with one reusable window, and adds flow control, a word index and a flush.

## Interface
- WORD_W, default 32: word width, either 32 (SHA-256) or 64 (SHA-512); it selects the sigma constants.
- ROUNDS, default 64: schedule length, 64 for SHA-256 or 80 for SHA-512. ROUNDS must be divisible by STEPS.
- STEPS, default 1: words produced per handshake; legal values are 1, 2 and 4.
- CLK  in  1  single clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- in_valid  in  1  block_in is valid.
- in_ready  out  1  ready to load a block; high only in IDLE.
- block_in  in  16*WORD_W  message block; W_0 is in the MSBs, W_15 in the LSBs.
- flush  in  1  synchronous abort; returns the block to IDLE.
- w_valid  out  1  w_out holds valid words.
- w_ready  in  1  consumer accepts w_out.
- w_out  out  STEPS*WORD_W  W_t in the MSBs, W_{t+STEPS-1} in the LSBs.
- w_idx  out  7  t, the index of the MSB word of w_out.
- done  out  1  one-cycle pulse after the final word group is accepted.

## Operation
- Internal state:
  - 16-word window win[0..15], where win[0] = W_t.
  - counter t.
  - FSM with states IDLE and RUN.
- Sigma functions (ROTR = rotate right, SHR = logical shift right):
  - WORD_W=32: s0 = ROTR7^ROTR18^SHR3; s1 = ROTR17^ROTR19^SHR10.
  - WORD_W=64: s0 = ROTR1^ROTR8^SHR7; s1 = ROTR19^ROTR61^SHR6.
- Expansion, for j = 0..STEPS-1:
  - n_j = s1(x[14+j]) + x[9+j] + s0(x[1+j]) + x[j].
  - x is the window extended by n_0..n_{j-1}; the chain is combinational inside one cycle.
  - Additions are modulo 2^WORD_W; carries are discarded.
- IDLE:
  - in_ready=1 and w_valid=0.
  - On in_valid && in_ready: win ← block_in words, t ← 0, go to RUN.
- RUN:
  - w_valid=1, w_out = win[0..STEPS-1], w_idx = t.
  - in_valid is ignored.
  - On w_valid && w_ready with t+STEPS < ROUNDS: shift win left by STEPS, append n_0..n_{STEPS-1}, t ← t+STEPS.
  - On w_valid && w_ready with t+STEPS == ROUNDS: go to IDLE and assert done for the next cycle only. The window contents are don't-care afterwards.
  - w_ready low: all state holds and w_out stays stable (no bubbles, no drops).
- flush:
  - Has priority over every handshake; forces IDLE and t ← 0 on the next edge.
  - No done pulse, even when it coincides with the final accept.
  - In IDLE, flush also blocks a load in the same cycle.
- Reset (RST=0, any time including mid-block):
  - Immediately sets IDLE, t=0, window=0, w_valid=0, done=0, w_out=0, w_idx=0.
  - in_ready goes to 1 once in IDLE.

## Timing
- Reset values: in_ready=1, w_valid=0, w_out=0, w_idx=0, done=0.
- Load-to-first-word latency: 1 cycle. Load at edge k gives w_valid=1 with W_0 in cycle k+1.
- Throughput: one word group per cycle while w_ready=1. A full block takes ROUNDS/STEPS cycles in RUN.
- done is high in the cycle after the last accept, together with in_ready=1. A new block loads at the earliest in that same cycle.
- Block-to-block gap: minimum 1 IDLE cycle, so a block occupies ROUNDS/STEPS + 1 cycles.
- All outputs are registered or derived from state only; there is no combinational path from w_ready or in_valid to any output.

## Test plan
- **SHA-256 "abc" padded block, STEPS=1, w_ready=1.**
  - Stimulus: W_0=0x61626380, W_1..W_14=0, W_15=0x00000018.
  - Required: w_out=0x61626380 at idx 16, 0x000F0000 at idx 17; idx 0..63 match the golden model; done one cycle after idx 63 is accepted.
- **Same block, STEPS=4.**
  - Required: 16 handshakes; the group at idx 16 is {0x61626380, 0x000F0000, …} matching the golden model; done after the group at idx 60.
- **WORD_W=64, ROUNDS=80, SHA-512 "abc" block.**
  - Required: all 80 words match the golden model; W_17 = s1_512(0x18).
- **Random backpressure (w_ready ~50%).**
  - Required: w_out and w_idx stay stable while w_ready=0; the sequence is identical to the no-stall run; in_valid pulses during RUN are ignored.
- **flush at idx 30, then flush together with the final accept.**
  - Required: IDLE the next cycle, in_ready=1, no done pulse; the next block restarts at idx 0.
- **RST asserted mid-RUN, asynchronously between edges.**
  - Required: outputs reach their reset values without a clock edge; after release the block reloads cleanly.

Source files
------------

// File: rtl/sha2_w_sched_iter_if.sv
// Handshake bundle for the SHA-2 message-schedule generator.
// Block load on the input side, word-group stream on the output side.
interface sha2_w_sched_iter_if #(
  parameter int WORD_W = 32,
  parameter int STEPS  = 1
);
  logic                      in_valid;
  logic                      in_ready;
  logic [16*WORD_W-1:0]      block_in;
  logic                      flush;
  logic                      w_valid;
  logic                      w_ready;
  logic [STEPS*WORD_W-1:0]   w_out;
  logic [6:0]                w_idx;
  logic                      done;

  modport master (
    output in_valid, block_in, flush, w_ready,
    input  in_ready, w_valid, w_out, w_idx, done
  );

  modport slave (
    input  in_valid, block_in, flush, w_ready,
    output in_ready, w_valid, w_out, w_idx, done
  );
endinterface

// File: rtl/sha2_w_sched_iter.sv
// Iterative SHA-256/512 message schedule: one 16-word sliding window,
// STEPS new words chained per accepted handshake.
module sha2_w_sched_iter #(
  parameter int WORD_W = 32,
  parameter int ROUNDS = 64,
  parameter int STEPS  = 1
) (
  input logic               CLK,
  input logic               RST,
  sha2_w_sched_iter_if.slave bus
);
  localparam int BW = 16 * WORD_W;
  localparam int OW = STEPS * WORD_W;
  localparam logic [6:0] LAST = 7'(ROUNDS - STEPS);
  localparam logic [6:0] INC  = 7'(STEPS);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state_q;
  logic [6:0]      t_q;
  logic [BW-1:0]   win_q;
  logic [BW-1:0]   win_d;
  logic            done_q;

  function automatic logic [WORD_W-1:0] rotr(
    input logic [WORD_W-1:0] x,
    input int                n
  );
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic logic [WORD_W-1:0] sig0(
    input logic [WORD_W-1:0] x
  );
    if (WORD_W == 32)
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    else
      return rotr(x, 1) ^ rotr(x, 8) ^ (x >> 7);
  endfunction

  function automatic logic [WORD_W-1:0] sig1(
    input logic [WORD_W-1:0] x
  );
    if (WORD_W == 32)
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    else
      return rotr(x, 19) ^ rotr(x, 61) ^ (x >> 6);
  endfunction

  // Later new words feed on earlier ones in the same cycle, so the
  // window is extended in a scratch array before shifting.
  function automatic logic [BW-1:0] expand(
    input logic [BW-1:0] w
  );
    logic [WORD_W-1:0] x [16+STEPS];
    logic [OW-1:0]     n;
    for (int i = 0; i < 16; i++)
      x[i] = w[(15-i)*WORD_W +: WORD_W];
    n = '0;
    for (int j = 0; j < STEPS; j++) begin
      x[16+j] = sig1(x[14+j]) + x[9+j]
              + sig0(x[1+j]) + x[j];
      n[(STEPS-1-j)*WORD_W +: WORD_W] = x[16+j];
    end
    return (w << OW) | BW'(n);
  endfunction

  // Next window after one accepted word group.
  always_comb begin
    win_d = expand(win_q);
  end

  assign bus.in_ready = (state_q == IDLE);
  assign bus.w_valid  = (state_q == RUN);
  assign bus.w_out    = win_q[BW-1 -: OW];
  assign bus.w_idx    = t_q;
  assign bus.done     = done_q;

  // Load, advance and terminate the block; flush overrides all.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      t_q     <= '0;
      win_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.flush) begin
        state_q <= IDLE;
        t_q     <= '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (bus.in_valid) begin
              win_q   <= bus.block_in;
              t_q     <= '0;
              state_q <= RUN;
            end
          end
          RUN: begin
            if (bus.w_ready) begin
              if (t_q == LAST) begin
                state_q <= IDLE;
                t_q     <= '0;
                done_q  <= 1'b1;
              end else begin
                win_q <= win_d;
                t_q   <= t_q + INC;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_sha2_w_sched_iter.sv
// Bench for sha2_w_sched_iter: SHA-256 (1 and 4 words/step) and
// SHA-512 instances against a straight-line schedule model.
module tb_sha2_w_sched_iter;
  typedef logic [31:0] w32_t;
  typedef logic [63:0] w64_t;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  sha2_w_sched_iter_if #(.WORD_W(32), .STEPS(1)) ia();
  sha2_w_sched_iter_if #(.WORD_W(32), .STEPS(4)) ib();
  sha2_w_sched_iter_if #(.WORD_W(64), .STEPS(1)) ic();

  sha2_w_sched_iter #(.WORD_W(32), .ROUNDS(64), .STEPS(1)) ua (
    .CLK(CLK), .RST(RST), .bus(ia.slave));
  sha2_w_sched_iter #(.WORD_W(32), .ROUNDS(64), .STEPS(4)) ub (
    .CLK(CLK), .RST(RST), .bus(ib.slave));
  sha2_w_sched_iter #(.WORD_W(64), .ROUNDS(80), .STEPS(1)) uc (
    .CLK(CLK), .RST(RST), .bus(ic.slave));

  int n_assert = 0;
  int n_fail   = 0;

  w32_t m32 [64];
  w64_t m64 [80];
  w32_t seen_a [64];
  logic [127:0] seen_b16;
  w64_t seen_c17;

  function automatic w32_t r32(input w32_t x, input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  function automatic w64_t r64(input w64_t x, input int n);
    logic [127:0] d;
    d = {x, x} >> n;
    return d[63:0];
  endfunction

  function automatic w32_t s0_32(input w32_t x);
    return r32(x, 7) ^ r32(x, 18) ^ (x >> 3);
  endfunction
  function automatic w32_t s1_32(input w32_t x);
    return r32(x, 17) ^ r32(x, 19) ^ (x >> 10);
  endfunction
  function automatic w64_t s0_64(input w64_t x);
    return r64(x, 1) ^ r64(x, 8) ^ (x >> 7);
  endfunction
  function automatic w64_t s1_64(input w64_t x);
    return r64(x, 19) ^ r64(x, 61) ^ (x >> 6);
  endfunction

  task automatic build32();
    for (int t = 16; t < 64; t++)
      m32[t] = s1_32(m32[t-2]) + m32[t-7] + s0_32(m32[t-15]) + m32[t-16];
  endtask

  task automatic build64();
    for (int t = 16; t < 80; t++)
      m64[t] = s1_64(m64[t-2]) + m64[t-7] + s0_64(m64[t-15]) + m64[t-16];
  endtask

  function automatic logic [511:0] pack32();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[(15-i)*32 +: 32] = m32[i];
    return b;
  endfunction

  function automatic logic [1023:0] pack64();
    logic [1023:0] b;
    for (int i = 0; i < 16; i++) b[(15-i)*64 +: 64] = m64[i];
    return b;
  endfunction

  task automatic abc32();
    for (int i = 0; i < 16; i++) m32[i] = '0;
    m32[0]  = 32'h61626380;
    m32[15] = 32'h00000018;
    build32();
  endtask

  task automatic rnd32();
    for (int i = 0; i < 16; i++) m32[i] = $urandom;
    build32();
  endtask

  task automatic chk(input string tag, input logic [255:0] obs,
                     input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // SHA-256, one word per step, optional stalls and stray loads.
  task automatic run_a(input int stall_pct, input bit noise);
    int t;
    int budget;
    bit rdy;
    @(negedge CLK);
    chk("a_in_ready", 256'(ia.in_ready), 256'(1));
    ia.in_valid = 1'b1;
    ia.block_in = pack32();
    ia.w_ready  = 1'b0;
    @(negedge CLK);
    ia.in_valid = 1'b0;
    t = 0;
    budget = 0;
    while (t < 64 && budget < 2000) begin
      chk("a_valid", 256'(ia.w_valid), 256'(1));
      chk("a_idx", 256'(ia.w_idx), 256'(t));
      chk("a_wout", 256'(ia.w_out), 256'(m32[t]));
      chk("a_done_run", 256'(ia.done), 256'(0));
      seen_a[t] = ia.w_out;
      rdy = ($urandom_range(99) >= stall_pct);
      ia.w_ready = rdy;
      if (noise) begin
        ia.in_valid = 1'($urandom_range(1));
        ia.block_in = {16{$urandom}};
      end
      @(negedge CLK);
      if (rdy) t++;
      budget++;
    end
    ia.w_ready  = 1'b0;
    ia.in_valid = 1'b0;
    chk("a_budget", 256'(t), 256'(64));
    chk("a_done_pulse", 256'(ia.done), 256'(1));
    chk("a_done_ready", 256'(ia.in_ready), 256'(1));
    chk("a_done_valid", 256'(ia.w_valid), 256'(0));
    @(negedge CLK);
    chk("a_done_low", 256'(ia.done), 256'(0));
  endtask

  // Stream SHA-256 until index stop is shown, then flush with w_ready=1.
  task automatic flush_at(input int stop);
    ia.in_valid = 1'b1;
    ia.block_in = pack32();
    @(negedge CLK);
    ia.in_valid = 1'b0;
    ia.w_ready  = 1'b1;
    for (int t = 0; t < stop; t++) @(negedge CLK);
    chk("f_idx", 256'(ia.w_idx), 256'(stop));
    chk("f_wout", 256'(ia.w_out), 256'(m32[stop]));
    ia.flush = 1'b1;
    @(negedge CLK);
    ia.flush   = 1'b0;
    ia.w_ready = 1'b0;
    chk("f_ready", 256'(ia.in_ready), 256'(1));
    chk("f_valid", 256'(ia.w_valid), 256'(0));
    chk("f_nodone", 256'(ia.done), 256'(0));
    chk("f_idx0", 256'(ia.w_idx), 256'(0));
    @(negedge CLK);
    chk("f_nodone2", 256'(ia.done), 256'(0));
  endtask

  initial begin
    RST = 1'b0;
    ia.in_valid = 0; ia.block_in = '0; ia.flush = 0; ia.w_ready = 0;
    ib.in_valid = 0; ib.block_in = '0; ib.flush = 0; ib.w_ready = 0;
    ic.in_valid = 0; ic.block_in = '0; ic.flush = 0; ic.w_ready = 0;
    repeat (2) @(negedge CLK);
    chk("rst_a_ready", 256'(ia.in_ready), 256'(1));
    chk("rst_a_valid", 256'(ia.w_valid), 256'(0));
    chk("rst_a_wout", 256'(ia.w_out), 256'(0));
    chk("rst_a_idx", 256'(ia.w_idx), 256'(0));
    chk("rst_a_done", 256'(ia.done), 256'(0));
    chk("rst_b_wout", 256'(ib.w_out), 256'(0));
    chk("rst_c_wout", 256'(ic.w_out), 256'(0));
    chk("rst_c_ready", 256'(ic.in_ready), 256'(1));
    RST = 1'b1;

    // "abc" block, no stalls
    abc32();
    run_a(0, 1'b0);
    chk("abc_w16", 256'(seen_a[16]), 256'(32'h61626380));
    chk("abc_w17", 256'(seen_a[17]), 256'(32'h000F0000));

    // random blocks, ~50% backpressure, stray in_valid during RUN
    rnd32();
    run_a(50, 1'b1);
    rnd32();
    run_a(50, 1'b1);

    // four words per step
    abc32();
    @(negedge CLK);
    chk("b_in_ready", 256'(ib.in_ready), 256'(1));
    ib.in_valid = 1'b1;
    ib.block_in = pack32();
    @(negedge CLK);
    ib.in_valid = 1'b0;
    ib.w_ready  = 1'b1;
    for (int h = 0; h < 16; h++) begin
      chk("b_valid", 256'(ib.w_valid), 256'(1));
      chk("b_idx", 256'(ib.w_idx), 256'(4*h));
      chk("b_wout", 256'(ib.w_out),
          256'({m32[4*h], m32[4*h+1], m32[4*h+2], m32[4*h+3]}));
      chk("b_done_run", 256'(ib.done), 256'(0));
      if (h == 4) seen_b16 = ib.w_out;
      @(negedge CLK);
    end
    ib.w_ready = 1'b0;
    chk("b_done_pulse", 256'(ib.done), 256'(1));
    chk("b_done_ready", 256'(ib.in_ready), 256'(1));
    chk("b_w16_w17", 256'(seen_b16[127:64]),
        256'(64'h61626380_000F0000));
    @(negedge CLK);
    chk("b_done_low", 256'(ib.done), 256'(0));

    // SHA-512 "abc" block, ~30% stalls
    for (int i = 0; i < 16; i++) m64[i] = '0;
    m64[0]  = 64'h6162638000000000;
    m64[15] = 64'h18;
    build64();
    ic.in_valid = 1'b1;
    ic.block_in = pack64();
    @(negedge CLK);
    ic.in_valid = 1'b0;
    begin
      int t;
      int budget;
      bit rdy;
      t = 0;
      budget = 0;
      while (t < 80 && budget < 2000) begin
        chk("c_valid", 256'(ic.w_valid), 256'(1));
        chk("c_idx", 256'(ic.w_idx), 256'(t));
        chk("c_wout", 256'(ic.w_out), 256'(m64[t]));
        if (t == 17) seen_c17 = ic.w_out;
        rdy = ($urandom_range(99) >= 30);
        ic.w_ready = rdy;
        @(negedge CLK);
        if (rdy) t++;
        budget++;
      end
      ic.w_ready = 1'b0;
      chk("c_budget", 256'(t), 256'(80));
    end
    chk("c_done_pulse", 256'(ic.done), 256'(1));
    chk("c_w17", 256'(seen_c17), 256'(64'h00030000000000C0));

    // flush mid-block, then flush on the final accept
    rnd32();
    flush_at(30);
    abc32();
    run_a(0, 1'b0);
    rnd32();
    flush_at(63);
    rnd32();
    run_a(20, 1'b0);

    // flush in IDLE blocks a load
    @(negedge CLK);
    ia.in_valid = 1'b1;
    ia.flush    = 1'b1;
    @(negedge CLK);
    ia.in_valid = 1'b0;
    ia.flush    = 1'b0;
    chk("fi_ready", 256'(ia.in_ready), 256'(1));
    chk("fi_valid", 256'(ia.w_valid), 256'(0));

    // asynchronous reset mid-block
    abc32();
    ia.in_valid = 1'b1;
    ia.block_in = pack32();
    @(negedge CLK);
    ia.in_valid = 1'b0;
    ia.w_ready  = 1'b1;
    repeat (5) @(negedge CLK);
    chk("ar_idx_pre", 256'(ia.w_idx), 256'(5));
    #2;
    RST = 1'b0;
    #1;
    chk("ar_valid", 256'(ia.w_valid), 256'(0));
    chk("ar_wout", 256'(ia.w_out), 256'(0));
    chk("ar_idx", 256'(ia.w_idx), 256'(0));
    chk("ar_done", 256'(ia.done), 256'(0));
    chk("ar_ready", 256'(ia.in_ready), 256'(1));
    ia.w_ready = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    rnd32();
    run_a(50, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end
endmodule
